pipeline_stall_sequencer: RTL and testbench
===========================================

// Module: pipeline_stall_sequencer
// PURPOSE
//  Central pipeline-register sequencer. Merges the hazard unit's load-use stall, EX-stage branch-taken
//  redirects and multi-cycle data-memory waits into one prioritised set of load enables, bubble
//  injection and flushes. Sits beside hazard_forwarding_unit, driving PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles flush_if_id stays asserted after a taken branch (1..3)
//  MEM_TIMEOUT   15  max consecutive MEM_WAIT cycles before ERROR (1..255)
//  CNT_W         16  width of each performance counter
// PORTS
//  clk              in   1      pipeline clock
//  reset            in   1      synchronous, active-high reset
//  load_use_stall   in   1      hazard unit load-use request (1 = stall ID for one cycle)
//  branch_taken     in   1      EX stage resolved taken branch; PC loads target this cycle
//  mem_req          in   1      MEM stage instruction accesses data memory
//  mem_ready        in   1      data memory completes access this cycle
//  le_pc, le_if_id  out  1 ea   load enables, 1 = load
//  le_id_ex, le_ex_mem, le_mem_wb  out 1 ea  load enables, 1 = load
//  nop_n            out  1      0 = inject bubble into ID/EX (hazard-unit NOP polarity)
//  flush_if_id      out  1      1 = clear IF/ID to NOP on next edge
//  mem_timeout      out  1      sticky error flag
//  stall_cnt, flush_cnt, mem_wait_cnt  out CNT_W ea  performance counters
// BEHAVIOUR
//  - State register only; outputs are combinational decode of state + inputs (zero-latency stalls).
//  - Reset asserted: state=RUN, flush counter=0, wait counter=0, mem_timeout=0, perf counters=0;
//    outputs while reset high: all le_*=0, nop_n=0, flush_if_id=0.
//  - States: RUN, FLUSH, MEM_WAIT, ERROR.
//  - RUN, priority mem > branch > load-use:
//    mem_req & !mem_ready -> all le_*=0, nop_n=1; next MEM_WAIT, wait counter=1.
//    else branch_taken -> all le_*=1, flush_if_id=1, nop_n=0; next FLUSH if FLUSH_CYCLES>1,
//      else stay RUN. Simultaneous load_use_stall is ignored (stalled instruction is squashed).
//    else load_use_stall -> le_pc=le_if_id=0, nop_n=0, other le_*=1; stay RUN.
//    else all le_*=1, nop_n=1, flush_if_id=0.
//  - FLUSH: flush_if_id=1, nop_n=0, all le_*=1; counts down FLUSH_CYCLES-1 more cycles, then RUN.
//    mem_req & !mem_ready in FLUSH -> MEM_WAIT behaviour, remaining flush cycles discarded.
//  - MEM_WAIT: all le_*=0, nop_n=1, flush_if_id=0; branch_taken/load_use_stall ignored (frozen).
//    mem_ready=1 -> this cycle evaluated as RUN (same priorities, mem term false); next per RUN rules.
//    wait counter == MEM_TIMEOUT with mem_ready=0 -> next ERROR, mem_timeout=1.
//  - ERROR: all le_*=0, nop_n=0, flush_if_id=0; exits only via reset.
//  - mem_ready without mem_req in RUN: ignored.
//  - Reset mid-MEM_WAIT/FLUSH: next cycle RUN, counters cleared, no residual flush.
// CONFIGURATION
//  - PIPE_PERF_COUNTERS_EN defined: stall_cnt += 1 each cycle le_pc=0 (load-use, MEM_WAIT, ERROR);
//    flush_cnt += 1 per taken branch accepted; mem_wait_cnt += 1 per MEM_WAIT cycle; all
//    saturate at {CNT_W{1'b1}}; cleared by reset.
//  - Undefined: counter ports remain, tied to 0; no counter flops generated.
// STRUCTURE
//  - pipe_ctrl_defs.vh: state encodings (RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2, ERROR=2'd3),
//    NOP_INSERT=1'b0 / NOP_PASS=1'b1 constants, shared with hazard_forwarding_unit users.
//  - Sub-module sat_event_counter #(CNT_W): clk, reset, inc -> count, saturating; instantiated 3x
//    inside the PIPE_PERF_COUNTERS_EN generate region.
// TESTING
//  1. load_use_stall=1 one cycle in RUN -> le_pc=le_if_id=0, nop_n=0, le_id_ex=1; next cycle all 1.
//  2. branch_taken=1, FLUSH_CYCLES=2 -> flush_if_id=1 for 2 cycles, le_pc=1 both; flush_cnt=1.
//  3. mem_req=1, mem_ready low 3 cycles then high -> all le_*=0 for 3 cycles, 1 on 4th;
//     mem_wait_cnt=3, stall_cnt=3.
//  4. MEM_TIMEOUT=4, mem_ready never high -> mem_timeout=1 after 4 wait cycles, all le_*=0 until
//     reset; reset -> mem_timeout=0, RUN.
//  5. branch_taken & load_use_stall & mem_req&!mem_ready same cycle -> MEM_WAIT wins; on mem_ready
//     with branch_taken still high -> flush_if_id=1, load-use ignored.
//  6. PIPE_PERF_COUNTERS_EN, CNT_W=4, 20 load-use stalls -> stall_cnt holds 4'hF; undefined -> all 0.

Source files
------------

// File: rtl/pipeline_stall_sequencer_pkg.sv
// Shared pipeline-control constants: sequencer state codes, hazard-unit NOP polarity, control bundle.
// No logic of its own; used by the sequencer and anything decoding its state.
// No flow control involved.
package pipeline_stall_sequencer_pkg;

  // Sequencer state encodings (legacy-compatible plain constants)
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  // nop_n polarity shared with the hazard/forwarding unit
  localparam logic NOP_INSERT = 1'b0;
  localparam logic NOP_PASS   = 1'b1;

  // One cycle's worth of pipeline-register control
  typedef struct packed {
    logic le_pc;
    logic le_if_id;
    logic le_id_ex;
    logic le_ex_mem;
    logic le_mem_wb;
    logic nop_n;
    logic flush_if_id;
  } ctrl_t;

  // Front = PC and IF/ID, back = ID/EX, EX/MEM, MEM/WB
  function automatic ctrl_t mk_ctrl(input logic le_front, input logic le_back,
                                    input logic nop_n, input logic flush);
    ctrl_t c;
    c.le_pc       = le_front;
    c.le_if_id    = le_front;
    c.le_id_ex    = le_back;
    c.le_ex_mem   = le_back;
    c.le_mem_wb   = le_back;
    c.nop_n       = nop_n;
    c.flush_if_id = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_sequencer_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Latency: count reflects an event one cycle after it occurs.
// No backpressure; synchronous active-high reset clears the count.
module sat_event_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Count events, holding at the maximum value instead of wrapping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall sequencer: merges mem-wait, branch redirect and load-use into load enables/bubble/flush.
// Latency: outputs are a combinational decode of state + inputs (zero-cycle stall response).
// Backpressure: mem wait freezes every stage; optional perf counters under PIPE_PERF_COUNTERS_EN.
module pipeline_stall_sequencer
  import pipeline_stall_sequencer_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_use_stall_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             le_pc_o,
  output logic             le_if_id_o,
  output logic             le_id_ex_o,
  output logic             le_ex_mem_o,
  output logic             le_mem_wb_o,
  output logic             nop_n_o,
  output logic             flush_if_id_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] mem_wait_cnt_o
);

  // Flush cycles still owed after the branch cycle itself
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [1:0] flush_left_q, flush_left_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  ctrl_t ctrl;
  ctrl_t ctrl_out;
  logic  mem_stall;
  logic  run_eval;
  logic  branch_accepted;
  logic  mem_wait_cycle;

  assign mem_stall = mem_req_i & ~mem_ready_i;

  // Next-state and control decode; MEM_WAIT with mem_ready falls through to the RUN priorities
  always_comb begin
    state_d         = state_q;
    flush_left_d    = flush_left_q;
    wait_cnt_d      = wait_cnt_q;
    mem_timeout_d   = mem_timeout_q;
    ctrl            = mk_ctrl(1'b0, 1'b0, NOP_INSERT, 1'b0);
    run_eval        = 1'b0;
    branch_accepted = 1'b0;
    mem_wait_cycle  = 1'b0;

    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (mem_stall) begin
          // Memory wait overrides everything, including any remaining flush cycles
          ctrl           = mk_ctrl(1'b0, 1'b0, NOP_PASS, 1'b0);
          state_d        = ST_MEM_WAIT;
          wait_cnt_d     = 8'd1;
          flush_left_d   = 2'd0;
          mem_wait_cycle = 1'b1;
        end else if (state_q == ST_FLUSH) begin
          ctrl = mk_ctrl(1'b1, 1'b1, NOP_INSERT, 1'b1);
          if (flush_left_q <= 2'd1) begin
            state_d      = ST_RUN;
            flush_left_d = 2'd0;
          end else begin
            flush_left_d = flush_left_q - 2'd1;
          end
        end else begin
          run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          run_eval = 1'b1;
        end else begin
          // Frozen: branch and load-use requests are not looked at while waiting
          ctrl           = mk_ctrl(1'b0, 1'b0, NOP_PASS, 1'b0);
          mem_wait_cycle = 1'b1;
          if (wait_cnt_q >= TIMEOUT_LIM) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        // ERROR: whole pipeline held with bubbles until reset
        ctrl = mk_ctrl(1'b0, 1'b0, NOP_INSERT, 1'b0);
      end
    endcase

    if (run_eval) begin
      state_d    = ST_RUN;
      wait_cnt_d = 8'd0;
      if (branch_taken_i) begin
        // A concurrent load-use stall belongs to a squashed instruction, so it is dropped
        ctrl            = mk_ctrl(1'b1, 1'b1, NOP_INSERT, 1'b1);
        branch_accepted = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d      = ST_FLUSH;
          flush_left_d = FLUSH_RELOAD;
        end
      end else if (load_use_stall_i) begin
        ctrl = mk_ctrl(1'b0, 1'b1, NOP_INSERT, 1'b0);
      end else begin
        ctrl = mk_ctrl(1'b1, 1'b1, NOP_PASS, 1'b0);
      end
    end
  end

  // Everything held and no flush while reset is high
  always_comb begin
    ctrl_out = ctrl;
    if (reset_i) begin
      ctrl_out = mk_ctrl(1'b0, 1'b0, NOP_INSERT, 1'b0);
    end
  end

  // State, flush/wait counters and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_RUN;
      flush_left_q  <= 2'd0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign le_pc_o       = ctrl_out.le_pc;
  assign le_if_id_o    = ctrl_out.le_if_id;
  assign le_id_ex_o    = ctrl_out.le_id_ex;
  assign le_ex_mem_o   = ctrl_out.le_ex_mem;
  assign le_mem_wb_o   = ctrl_out.le_mem_wb;
  assign nop_n_o       = ctrl_out.nop_n;
  assign flush_if_id_o = ctrl_out.flush_if_id;
  assign mem_timeout_o = mem_timeout_q;

`ifdef PIPE_PERF_COUNTERS_EN
  sat_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (~ctrl_out.le_pc),
    .count_o (stall_cnt_o)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (branch_accepted),
    .count_o (flush_cnt_o)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (mem_wait_cycle),
    .count_o (mem_wait_cnt_o)
  );
`else
  assign stall_cnt_o    = '0;
  assign flush_cnt_o    = '0;
  assign mem_wait_cnt_o = '0;

  logic unused_perf_events;
  assign unused_perf_events = branch_accepted ^ mem_wait_cycle;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
module tb_pipeline_stall_sequencer;

  localparam int FC = 2;
  localparam int MT = 4;
  localparam int CW = 4;
`ifdef PIPE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, lus, br, mreq, mrdy;
  logic le_pc, le_if_id, le_id_ex, le_ex_mem, le_mem_wb, nop_n, flush_if_id, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, mem_wait_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stall_sequencer #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .load_use_stall_i (lus),
    .branch_taken_i   (br),
    .mem_req_i        (mreq),
    .mem_ready_i      (mrdy),
    .le_pc_o          (le_pc),
    .le_if_id_o       (le_if_id),
    .le_id_ex_o       (le_id_ex),
    .le_ex_mem_o      (le_ex_mem),
    .le_mem_wb_o      (le_mem_wb),
    .nop_n_o          (nop_n),
    .flush_if_id_o    (flush_if_id),
    .mem_timeout_o    (mem_timeout),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt),
    .mem_wait_cnt_o   (mem_wait_cnt)
  );

  // Reference model: "waiting", "error", flush cycles owed, unbounded event tallies
  bit m_err, m_wait, m_to;
  int m_mw, m_fl, m_stall, m_flush, m_memw;
  bit n_err, n_wait, n_to;
  int n_mw, n_fl, n_stall, n_flush, n_memw;
  // {le_pc, le_if_id, le_id_ex, le_ex_mem, le_mem_wb, nop_n, flush_if_id, mem_timeout}
  logic [7:0] exp_o;

  function automatic logic [7:0] obs();
    return {le_pc, le_if_id, le_id_ex, le_ex_mem, le_mem_wb, nop_n, flush_if_id, mem_timeout};
  endfunction

  function automatic logic [CW-1:0] sat(input int v);
    int mx;
    mx = (1 << CW) - 1;
    if (!PERF) return '0;
    return (v >= mx) ? CW'(mx) : CW'(v);
  endfunction

  task automatic model_eval();
    n_err = m_err; n_wait = m_wait; n_to = m_to; n_mw = m_mw; n_fl = m_fl;
    n_stall = m_stall; n_flush = m_flush; n_memw = m_memw;
    if (reset) begin
      exp_o = {7'b0000000, m_to};
      n_err = 0; n_wait = 0; n_to = 0; n_mw = 0; n_fl = 0;
      n_stall = 0; n_flush = 0; n_memw = 0;
    end else if (m_err) begin
      exp_o = {7'b0000000, m_to};
      n_stall++;
    end else if (m_wait && !mrdy) begin
      exp_o = {7'b0000010, m_to};
      n_stall++; n_memw++;
      n_mw = m_mw + 1;
      if (n_mw == MT) begin n_err = 1; n_to = 1; end
    end else if (!m_wait && mreq && !mrdy) begin
      exp_o = {7'b0000010, m_to};
      n_stall++; n_memw++;
      n_wait = 1; n_mw = 0; n_fl = 0;
    end else if (!m_wait && m_fl > 0) begin
      exp_o = {7'b1111101, m_to};
      n_fl = m_fl - 1;
    end else begin
      n_wait = 0;
      if (br) begin
        exp_o = {7'b1111101, m_to};
        n_fl = FC - 1; n_flush++;
      end else if (lus) begin
        exp_o = {7'b0011100, m_to};
        n_stall++;
      end else begin
        exp_o = {7'b1111110, m_to};
      end
    end
  endtask

  task automatic model_commit();
    m_err = n_err; m_wait = n_wait; m_to = n_to; m_mw = n_mw; m_fl = n_fl;
    m_stall = n_stall; m_flush = n_flush; m_memw = n_memw;
  endtask

  // Pattern bits: {reset, load_use, branch, mem_req, mem_ready}
  task automatic drive(input logic [4:0] p);
    {reset, lus, br, mreq, mrdy} = p;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    drive({1'b1, 4'($urandom_range(15))});
    tick();
    for (int i = 0; i < 3; i++) begin
      drive({1'b1, 4'($urandom_range(15))});
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL reset_outputs cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    drive(5'b00000);
    n_checks++;
    if (obs() !== exp_o) begin
      n_fail++; $display("FAIL reset_release got %b want %b", obs(), exp_o);
    end
    n_checks++;
    if ({stall_cnt, flush_cnt, mem_wait_cnt} !== {sat(m_stall), sat(m_flush), sat(m_memw)}) begin
      n_fail++; $display("FAIL reset_counters got %h/%h/%h want 0", stall_cnt, flush_cnt, mem_wait_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] seq [4] = '{5'b00000, 5'b01000, 5'b00000, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL load_use cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
  endtask

  task automatic test_branch_flush();
    logic [4:0] seq [5] = '{5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL branch_flush cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    n_checks++;
    if (flush_cnt !== sat(m_flush)) begin
      n_fail++; $display("FAIL branch_flush_cnt got %0d want %0d", flush_cnt, sat(m_flush));
    end
  endtask

  task automatic test_mem_wait();
    logic [4:0] seq [6] = '{5'b00010, 5'b00010, 5'b00010, 5'b00011, 5'b00000, 5'b00001};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL mem_wait cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    n_checks++;
    if ({stall_cnt, mem_wait_cnt} !== {sat(m_stall), sat(m_memw)}) begin
      n_fail++; $display("FAIL mem_wait_counters got %0d/%0d want %0d/%0d",
                         stall_cnt, mem_wait_cnt, sat(m_stall), sat(m_memw));
    end
  endtask

  task automatic test_timeout();
    drive(5'b10000);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(5'b00010);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL timeout cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    drive(5'b10000);
    tick();
    drive(5'b00000);
    n_checks++;
    if (obs() !== exp_o) begin
      n_fail++; $display("FAIL timeout_clear got %b want %b", obs(), exp_o);
    end
    tick();
  endtask

  task automatic test_priority();
    logic [4:0] seq [7] = '{5'b01110, 5'b01110, 5'b01110, 5'b01111, 5'b01000, 5'b00000, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i]);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL priority cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] seq [7] = '{5'b00100, 5'b10000, 5'b00000, 5'b00010, 5'b00010, 5'b10000, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i]);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL reset_mid cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    drive(5'b10000);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(5'b01000);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL saturation cyc%0d got %b want %b", i, obs(), exp_o);
      end
      tick();
    end
    n_checks++;
    if (stall_cnt !== sat(m_stall)) begin
      n_fail++; $display("FAIL saturation_stall_cnt got %h want %h", stall_cnt, sat(m_stall));
    end
  endtask

  task automatic test_random();
    logic [4:0] p;
    for (int i = 0; i < 500; i++) begin
      p[4] = ($urandom_range(99) < 2);
      p[3] = ($urandom_range(99) < 25);
      p[2] = ($urandom_range(99) < 20);
      p[1] = ($urandom_range(99) < 35);
      p[0] = ($urandom_range(99) < 50);
      drive(p);
      n_checks++;
      if (obs() !== exp_o) begin
        n_fail++; $display("FAIL random cyc%0d in %b got %b want %b", i, p, obs(), exp_o);
      end
      tick();
      n_checks++;
      if ({stall_cnt, flush_cnt, mem_wait_cnt} !== {sat(m_stall), sat(m_flush), sat(m_memw)}) begin
        n_fail++; $display("FAIL random_counters cyc%0d got %h/%h/%h want %h/%h/%h", i,
                           stall_cnt, flush_cnt, mem_wait_cnt, sat(m_stall), sat(m_flush), sat(m_memw));
      end
    end
  endtask

  initial begin
    {reset, lus, br, mreq, mrdy} = 5'b10000;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
